dram_cache_lookup: RTL and testbench
====================================

DRAM_CACHE_LOOKUP -- requirements
Module: dram_cache_lookup

Interface
REQ-001 Parameters SHALL be: ID_W, 16, AXI ID width; ID, 1, constant ID driven on arid_o.
REQ-002 Clock and reset SHALL be a single clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk only.
REQ-003 Ports SHALL be:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  lookup request valid
req_ready  out  1  lookup request accepted
req_addr  in  64  physical byte address
rsp_valid  out  1  lookup result valid
rsp_ready  in  1  result consumed
rsp_hit  out  1  tag hit
rsp_dirty  out  1  dirty bit of the hit line, 0 on miss
rsp_data  out  512  line data on hit, 0 on miss
hit_cnt_o  out  32  saturating hit counter
miss_cnt_o  out  32  saturating miss counter
arid_o  out  ID_W  read ID, constant ID
araddr_o  out  64  line address to the cache memory
arvalid_o  out  1  read address valid
arready_i  in  1  read address accepted
rdata_i  in  576  {tag word[63:0], data[511:0]}
rvalid_i  in  1  read data valid
rready_o  out  1  read data accepted

Function
REQ-004 The FSM SHALL have four states: IDLE, AR, R, RSP; at most one lookup is outstanding.
REQ-005 IDLE: req_ready=1; when req_valid=1, latch req_addr, go to AR. In all other states req_ready=0 and req_valid is ignored.
REQ-006 AR: arvalid_o=1, araddr_o={addr[63:6],6'b0}, held stable until arready_i=1; on arready_i=1, go to R.
REQ-007 R: rready_o=1; on rvalid_i=1, capture rdata_i, evaluate hit, update a counter, go to RSP. rvalid_i outside R SHALL be ignored.
REQ-008 Tag word layout: bit 63 valid, bit 62 dirty, bits 61:30 tag, bits 29:0 zero; the index is addr[31:6] and the offset is addr[5:0].
REQ-009 Hit SHALL be rdata_i[575]==1 AND rdata_i[573:542]==addr[63:32].
REQ-010 RSP: rsp_valid=1 and outputs are stable until rsp_ready=1; on rsp_ready=1, go to IDLE. A new request SHALL be accepted no earlier than the cycle after.
REQ-011 On a hit, rsp_data=rdata_i[511:0] and rsp_dirty=rdata_i[574]. On a miss, rsp_data=0 and rsp_dirty=0.
REQ-012 hit_cnt_o/miss_cnt_o SHALL increment by 1 at R capture and saturate at 32'hFFFF_FFFF without wrapping.
REQ-013 Against a memory that asserts arready one cycle after arvalid and rvalid combinationally in its RUN state:
- req accepted at cycle 0
- arvalid_o at cycle 1
- capture at cycle 3
- rsp_valid at cycle 4

Reset
REQ-014 When rst=1, the block SHALL go to IDLE from any state, including mid-transaction.
REQ-015 Reset values SHALL be: req_ready=0 during reset, arvalid_o=0, rready_o=0, rsp_valid=0, rsp_hit=0, rsp_dirty=0, rsp_data=0, counters=0, araddr_o=0. arid_o is always ID.

Structure
REQ-016 A shared package SHALL hold ADDR_W=64, DATA_W=512, TAG_S=64, INDEX_W=26, OFFSET_W=6, BLANK_W=30, the tag-word bit positions, and the FSM state enum.
REQ-017 The hit comparator SHALL be a sub-module dram_cache_tag_cmp (combinational: tag word, address -> hit, dirty).

Verification
REQ-018 Hit: line 5 preloaded with valid=1 and tag=0x0000_0001; req_addr=0x1_0000_0140 -> rsp_hit=1, rsp_data=the stored line, hit_cnt_o=1.
REQ-019 Miss: valid=0 at index 5, same address -> rsp_hit=0, rsp_data=0, miss_cnt_o=1.
REQ-020 Backpressure: rsp_ready held at 0 for 10 cycles -> rsp_valid and rsp_data stable, req_ready=0, and a second req_valid is not accepted.
REQ-021 Slow arready (5-cycle delay) -> araddr_o stable throughout, exactly one AR handshake, and the latency of REQ-013 extended by 4 cycles.
REQ-022 Reset pulse while in state R -> the next cycle has arvalid_o=0, rready_o=0, rsp_valid=0 and counters=0; a subsequent lookup completes normally.
REQ-023 Counter forced to 32'hFFFF_FFFE followed by 3 hits -> hit_cnt_o=32'hFFFF_FFFF.

Source files
------------

// File: rtl/dram_cache_lookup_pkg.sv
// rtl/dram_cache_lookup_pkg.sv - shared widths, tag-word layout and lookup FSM states
package dram_cache_lookup_pkg;
    localparam int ADDR_W        = 64;
    localparam int DATA_W        = 512;
    localparam int TAG_S         = 64;
    localparam int INDEX_W       = 26;
    localparam int OFFSET_W      = 6;
    localparam int BLANK_W       = 30;
    localparam int TAG_VALID_BIT = 63;
    localparam int TAG_DIRTY_BIT = 62;
    localparam int TAG_MSB       = 61;
    localparam int TAG_LSB       = 30;
    localparam int TAG_W         = TAG_MSB - TAG_LSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_RSP
    } state_t;
endpackage

// File: rtl/dram_cache_tag_cmp.sv
// rtl/dram_cache_tag_cmp.sv - combinational tag-word compare producing hit and dirty
module dram_cache_tag_cmp
    import dram_cache_lookup_pkg::*;
(
    input  logic [TAG_S-1:0]  i_tag_word,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_hit,
    output logic              o_dirty
);
    // Blank tag bits and index/offset address bits take no part in the compare
    logic w_unused;
    assign w_unused = ^{i_tag_word[BLANK_W-1:0], i_addr[ADDR_W-TAG_W-1:0]};

    assign o_hit   = i_tag_word[TAG_VALID_BIT] &&
                     (i_tag_word[TAG_MSB:TAG_LSB] == i_addr[ADDR_W-1:ADDR_W-TAG_W]);
    assign o_dirty = o_hit && i_tag_word[TAG_DIRTY_BIT];
endmodule

// File: rtl/dram_cache_lookup.sv
// rtl/dram_cache_lookup.sv - single-outstanding DRAM cache tag lookup over a read channel
module dram_cache_lookup
    import dram_cache_lookup_pkg::*;
#(
    parameter int ID_W = 16,
    parameter int ID   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_hit,
    output logic                  rsp_dirty,
    output logic [DATA_W-1:0]     rsp_data,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o,
    output logic [ID_W-1:0]       arid_o,
    output logic [ADDR_W-1:0]     araddr_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [TAG_S+DATA_W-1:0] rdata_i,
    input  logic                  rvalid_i,
    output logic                  rready_o
);
    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_hit;
    logic                r_dirty;
    logic [DATA_W-1:0]   r_data;
    logic [31:0]         r_hit_cnt;
    logic [31:0]         r_miss_cnt;
    logic                w_hit;
    logic                w_dirty;
    logic                w_capture;

    dram_cache_tag_cmp u_tag_cmp (
        .i_tag_word (rdata_i[DATA_W +: TAG_S]),
        .i_addr     (r_addr),
        .o_hit      (w_hit),
        .o_dirty    (w_dirty)
    );

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        arvalid_o   = 1'b0;
        rready_o    = 1'b0;
        rsp_valid   = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = !rst;
                if (req_valid) w_state_nxt = ST_AR;
            end
            ST_AR: begin
                arvalid_o = 1'b1;
                if (arready_i) w_state_nxt = ST_R;
            end
            ST_R: begin
                rready_o = 1'b1;
                if (rvalid_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RSP;
                end
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_hit      <= 1'b0;
            r_dirty    <= 1'b0;
            r_data     <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && req_valid) r_addr <= req_addr;
            if (w_capture) begin
                r_hit   <= w_hit;
                r_dirty <= w_dirty;
                r_data  <= w_hit ? rdata_i[DATA_W-1:0] : '0;
                // Counters stick at all-ones instead of wrapping
                if (w_hit) begin
                    if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
                end else begin
                    if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
                end
            end
        end
    end

    assign rsp_hit    = r_hit;
    assign rsp_dirty  = r_dirty;
    assign rsp_data   = r_data;
    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
    assign araddr_o   = {r_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign arid_o     = ID_W'(ID);
endmodule

// File: tb/tb_dram_cache_lookup.sv
// tb/tb_dram_cache_lookup.sv - scoreboard bench for dram_cache_lookup against a behavioural cache memory
module tb_dram_cache_lookup;
    localparam logic [63:0] HIT_ADDR = 64'h0000_0001_0000_0140;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [63:0]  req_addr = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic         rsp_hit;
    logic         rsp_dirty;
    logic [511:0] rsp_data;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;
    logic [15:0]  arid_o;
    logic [63:0]  araddr_o;
    logic         arvalid_o;
    logic         arready_i = 1'b0;
    logic [575:0] rdata_i;
    logic         rvalid_i;
    logic         rready_o;

    typedef struct packed {
        logic         hit;
        logic         dirty;
        logic [511:0] data;
    } exp_t;

    typedef enum logic {M_IDLE, M_RUN} m_state_t;

    exp_t         sb[$];
    logic [575:0] mem [0:63];
    m_state_t     m_state = M_IDLE;
    int           m_cnt = 0;
    int           ar_delay = 1;
    int           ar_hs_cnt = 0;
    logic [63:0]  m_addr = '0;
    logic         r_hold = 1'b0;
    logic [31:0]  exp_hits = '0;
    logic [31:0]  exp_misses = '0;
    int           checks = 0;
    int           errors = 0;

    dram_cache_lookup #(.ID_W(16), .ID(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_hit    (rsp_hit),
        .rsp_dirty  (rsp_dirty),
        .rsp_data   (rsp_data),
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o),
        .arid_o     (arid_o),
        .araddr_o   (araddr_o),
        .arvalid_o  (arvalid_o),
        .arready_i  (arready_i),
        .rdata_i    (rdata_i),
        .rvalid_i   (rvalid_i),
        .rready_o   (rready_o)
    );

    always #5 clk = ~clk;

    // Memory: arready after ar_delay cycles of arvalid, rvalid combinational while running
    always @(posedge clk) begin
        if (rst) begin
            m_state   <= M_IDLE;
            arready_i <= 1'b0;
            m_cnt     <= 0;
        end else if (m_state == M_IDLE) begin
            if (arvalid_o && arready_i) begin
                arready_i <= 1'b0;
                m_cnt     <= 0;
                m_addr    <= araddr_o;
                m_state   <= M_RUN;
                ar_hs_cnt <= ar_hs_cnt + 1;
            end else if (arvalid_o) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt + 1 >= ar_delay) arready_i <= 1'b1;
            end
        end else if (rvalid_i && rready_o) begin
            m_state <= M_IDLE;
        end
    end

    assign rvalid_i = (m_state == M_RUN) && !r_hold;
    assign rdata_i  = mem[m_addr[11:6]];

    function automatic logic [63:0] tag_word(input logic v, input logic d, input logic [31:0] t);
        return {v, d, t, 30'b0};
    endfunction

    function automatic exp_t model(input logic [63:0] a);
        logic [575:0] w;
        logic [63:0]  t;
        exp_t         e;
        w       = mem[a[11:6]];
        t       = w[575:512];
        e.hit   = t[63] && (t[61:30] == a[63:32]);
        e.dirty = e.hit && t[62];
        e.data  = e.hit ? w[511:0] : '0;
        return e;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic push_expect(input logic [63:0] addr);
        exp_t e;
        e = model(addr);
        sb.push_back(e);
        if (e.hit) exp_hits = (exp_hits == '1) ? exp_hits : exp_hits + 32'd1;
        else       exp_misses = (exp_misses == '1) ? exp_misses : exp_misses + 32'd1;
    endtask

    task automatic send_req(input logic [63:0] addr);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic run_lookup(input logic [63:0] addr, output exp_t obs, output int lat, output int bad_ar);
        push_expect(addr);
        bad_ar = 0;
        send_req(addr);
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            if (arvalid_o && araddr_o !== {addr[63:6], 6'b0}) bad_ar++;
            @(negedge clk);
            lat++;
        end
        obs = {rsp_hit, rsp_dirty, rsp_data};
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++; if (arvalid_o !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b expected 0", arvalid_o); end
        checks++; if (rready_o !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b expected 0", rready_o); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if ({rsp_hit, rsp_dirty} !== 2'b00) begin errors++; $display("FAIL reset_rsp_flags: got %b expected 00", {rsp_hit, rsp_dirty}); end
        checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        checks++; if ({hit_cnt_o, miss_cnt_o} !== 64'd0) begin errors++; $display("FAIL reset_counters: got %h/%h expected 0/0", hit_cnt_o, miss_cnt_o); end
        checks++; if (araddr_o !== 64'd0) begin errors++; $display("FAIL reset_araddr: got %h expected 0", araddr_o); end
        checks++; if (arid_o !== 16'd1) begin errors++; $display("FAIL reset_arid: got %h expected 1", arid_o); end
        rst = 1'b0;
        exp_hits = '0;
        exp_misses = '0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b expected 1", req_ready); end
    endtask

    task automatic check_rsp(input string name, input exp_t obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard: got empty queue expected one entry", name);
            return;
        end
        e = sb.pop_front();
        if (obs !== e) begin
            errors++;
            $display("FAIL %s_rsp: got hit=%b dirty=%b data=%h expected hit=%b dirty=%b data=%h",
                     name, obs.hit, obs.dirty, obs.data[63:0], e.hit, e.dirty, e.data[63:0]);
        end
    endtask

    task automatic test_hit();
        exp_t obs;
        int   lat, bad;
        mem[5] = {tag_word(1'b1, 1'b0, 32'h0000_0001), rand_line()};
        run_lookup(HIT_ADDR, obs, lat, bad);
        check_rsp("hit", obs);
        checks++; if (obs.hit !== 1'b1) begin errors++; $display("FAIL hit_flag: got %b expected 1", obs.hit); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL hit_latency: got %0d expected 4", lat); end
        checks++; if (hit_cnt_o !== 32'd1) begin errors++; $display("FAIL hit_cnt: got %0d expected 1", hit_cnt_o); end
    endtask

    task automatic test_miss();
        exp_t obs;
        int   lat, bad;
        mem[5][575] = 1'b0;
        run_lookup(HIT_ADDR, obs, lat, bad);
        check_rsp("miss", obs);
        checks++; if ({obs.hit, obs.dirty} !== 2'b00 || obs.data !== '0) begin errors++; $display("FAIL miss_zero: got hit=%b dirty=%b data=%h expected 0", obs.hit, obs.dirty, obs.data[63:0]); end
        checks++; if (miss_cnt_o !== 32'd1) begin errors++; $display("FAIL miss_cnt: got %0d expected 1", miss_cnt_o); end
        checks++; if (hit_cnt_o !== exp_hits) begin errors++; $display("FAIL miss_hit_cnt: got %0d expected %0d", hit_cnt_o, exp_hits); end
        mem[5][575] = 1'b1;
    endtask

    task automatic test_patterns();
        logic [63:0] addrs [4];
        exp_t        obs;
        int          lat, bad;
        mem[9]  = {tag_word(1'b1, 1'b1, 32'h0000_0002), rand_line()};
        mem[12] = {tag_word(1'b1, 1'b0, 32'hFFFF_FFFF), rand_line()};
        mem[20] = {tag_word(1'b0, 1'b1, 32'h0000_0007), rand_line()};
        addrs[0] = 64'h0000_0002_0000_0240;
        addrs[1] = 64'h0000_0003_0000_0240;
        addrs[2] = 64'hFFFF_FFFF_0000_033F;
        addrs[3] = 64'h0000_0007_0000_0500;
        for (int i = 0; i < 4; i++) begin
            run_lookup(addrs[i], obs, lat, bad);
            check_rsp($sformatf("pattern%0d", i), obs);
        end
        checks++; if (hit_cnt_o !== exp_hits || miss_cnt_o !== exp_misses) begin errors++; $display("FAIL pattern_counters: got %0d/%0d expected %0d/%0d", hit_cnt_o, miss_cnt_o, exp_hits, exp_misses); end
    endtask

    task automatic test_backpressure();
        exp_t         obs;
        logic [511:0] snap;
        int           hs0, n, bad;
        mem[5] = {tag_word(1'b1, 1'b1, 32'h0000_0001), rand_line()};
        hs0 = ar_hs_cnt;
        push_expect(HIT_ADDR);
        send_req(HIT_ADDR);
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        snap = rsp_data;
        req_valid = 1'b1;
        req_addr  = 64'h0000_0002_0000_0080;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== snap || req_ready !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); end
        obs = {rsp_hit, rsp_dirty, rsp_data};
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check_rsp("bp", obs);
        repeat (3) @(negedge clk);
        checks++; if (ar_hs_cnt - hs0 !== 1) begin errors++; $display("FAIL bp_ar_count: got %0d expected 1", ar_hs_cnt - hs0); end
        checks++; if (arvalid_o !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_second_req: got arvalid=%b req_ready=%b expected 0/1", arvalid_o, req_ready); end
    endtask

    task automatic test_slow_arready();
        exp_t obs;
        int   lat, bad, hs0;
        ar_delay = 5;
        hs0 = ar_hs_cnt;
        run_lookup(HIT_ADDR, obs, lat, bad);
        ar_delay = 1;
        check_rsp("slow", obs);
        checks++; if (lat !== 8) begin errors++; $display("FAIL slow_latency: got %0d expected 8", lat); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL slow_araddr: got %0d bad cycles expected 0", bad); end
        checks++; if (ar_hs_cnt - hs0 !== 1) begin errors++; $display("FAIL slow_ar_count: got %0d expected 1", ar_hs_cnt - hs0); end
    endtask

    task automatic test_reset_in_r();
        exp_t obs;
        int   lat, bad, n;
        r_hold = 1'b1;
        send_req(HIT_ADDR);
        n = 0;
        while (!rready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++; if (rready_o !== 1'b1) begin errors++; $display("FAIL rst_r_reach: got rready=%b expected 1", rready_o); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({arvalid_o, rready_o, rsp_valid} !== 3'b000) begin errors++; $display("FAIL rst_r_ctrl: got %b expected 000", {arvalid_o, rready_o, rsp_valid}); end
        checks++; if ({hit_cnt_o, miss_cnt_o} !== 64'd0) begin errors++; $display("FAIL rst_r_counters: got %0d/%0d expected 0/0", hit_cnt_o, miss_cnt_o); end
        rst = 1'b0;
        r_hold = 1'b0;
        exp_hits = '0;
        exp_misses = '0;
        run_lookup(HIT_ADDR, obs, lat, bad);
        check_rsp("rst_r_after", obs);
        checks++; if (lat !== 4 || hit_cnt_o !== 32'd1) begin errors++; $display("FAIL rst_r_resume: got lat=%0d hits=%0d expected 4/1", lat, hit_cnt_o); end
    endtask

    task automatic test_saturation();
        exp_t obs;
        int   lat, bad;
        @(negedge clk);
        force dut.r_hit_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.r_hit_cnt;
        exp_hits = 32'hFFFF_FFFE;
        @(negedge clk);
        checks++; if (hit_cnt_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_preset: got %h expected fffffffe", hit_cnt_o); end
        for (int i = 0; i < 3; i++) begin
            run_lookup(HIT_ADDR, obs, lat, bad);
            check_rsp($sformatf("sat%0d", i), obs);
            checks++; if (hit_cnt_o !== exp_hits) begin errors++; $display("FAIL sat_cnt%0d: got %h expected %h", i, hit_cnt_o, exp_hits); end
        end
        checks++; if (hit_cnt_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_final: got %h expected ffffffff", hit_cnt_o); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        test_reset();
        test_hit();
        test_miss();
        test_patterns();
        test_backpressure();
        test_slow_arready();
        test_reset_in_r();
        test_saturation();
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
